// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        FCT_ADD = 2'b00,
        FCT_SUB = 2'b01,
        FCT_MUL = 2'b10,
        FCT_DIV = 2'b11
    } fct_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_iter_step.sv
// One iteration of the multi-cycle datapath: a radix-2 shift-add step for MUL
// or a restoring shift-subtract step for DIV, on a {hi, lo} register pair.
module alu_iter_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        // MUL: add the multiplicand when the current multiplier bit is set, then shift right
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        // DIV: bring in the next dividend bit, MSB first, and trial-subtract the divisor
        shifted = {hi, lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, b});
        hi_nxt  = '0;
        lo_nxt  = '0;
        if (is_div) begin
            hi_nxt = fits ? WIDTH'(shifted - {1'b0, b}) : shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], fits};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB, WIDTH-cycle MUL (shift-add) and DIV
// (restoring), with results held stable between DONE entries.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [1:0]         fct_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] res_o,
    output logic [2*WIDTH-1:0] rem_o,
    output logic               div0_o
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    fct_e             fct_q, fct_in;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic [W2-1:0]    fast_res;

    alu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div (fct_q == FCT_DIV),
        .hi     (hi_q),
        .lo     (lo_q),
        .b      (b_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Next state, start acceptance and single-cycle results
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        fct_in   = fct_e'(fct_i);
        fast_res = '0;
        case (fct_in)
            FCT_ADD: fast_res = W2'(a_i) + W2'(b_i);
            FCT_SUB: fast_res = W2'(a_i) - W2'(b_i);
            default: fast_res = '0;
        endcase
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    accept = 1'b1;
                    if (fct_in == FCT_MUL || (fct_in == FCT_DIV && b_i != '0)) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            fct_q   <= FCT_ADD;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            res_o   <= '0;
            rem_o   <= '0;
            div0_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d == CALC);
            done_o  <= (state_d == DONE);
            if (accept) begin
                fct_q <= fct_in;
                b_q   <= b_i;
                hi_q  <= '0;
                lo_q  <= a_i;
                cnt_q <= '0;
                // Back-to-back starts into CALC keep the previous results visible
                if (state_d == DONE) begin
                    res_o  <= fast_res;
                    rem_o  <= '0;
                    div0_o <= (fct_in == FCT_DIV);
                end
            end else if (state_q == CALC) begin
                hi_q  <= hi_nxt;
                lo_q  <= lo_nxt;
                cnt_q <= cnt_q + CW'(1);
                if (state_d == DONE) begin
                    div0_o <= 1'b0;
                    if (fct_q == FCT_MUL) begin
                        res_o <= {hi_nxt, lo_nxt};
                        rem_o <= '0;
                    end else begin
                        res_o <= W2'(lo_nxt);
                        rem_o <= W2'(hi_nxt);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): expected results are queued at start
// and checked, with latency, when done_o rises.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  fct;
    logic [7:0]  a_v, b_v;
    logic        busy, done, div0;
    logic [15:0] res, rem;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [15:0] rem;
        logic        div0;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          ncmp = 0;
    int          nerr = 0;
    logic [15:0] last_res = '0;

    alu_seq #(.WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .fct_i   (fct),
        .a_i     (a_v),
        .b_i     (b_v),
        .busy_o  (busy),
        .done_o  (done),
        .res_o   (res),
        .rem_o   (rem),
        .div0_o  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Queue the expectation, drive the start for one edge, then scramble operands.
    task automatic issue(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b,
                         input string tag);
        exp_t e;
        e.tag  = tag;
        e.rem  = '0;
        e.div0 = 1'b0;
        e.lat  = 1;
        case (f)
            2'b00: e.res = 16'(a) + 16'(b);
            2'b01: e.res = 16'(a) - 16'(b);
            2'b10: begin e.res = 16'(a) * 16'(b); e.lat = 9; end
            default: begin
                if (b == 8'd0) begin
                    e.res  = '0;
                    e.div0 = 1'b1;
                end else begin
                    e.res = 16'(a / b);
                    e.rem = 16'(a % b);
                    e.lat = 9;
                end
            end
        endcase
        exp_q.push_back(e);
        fct   = f;
        a_v   = a;
        b_v   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fct   = 2'($urandom);
        a_v   = 8'($urandom);
        b_v   = 8'($urandom);
    endtask

    // Called in cycle n0 after the accepting edge; bounded wait for done_o.
    task automatic wait_done(input int n0);
        exp_t e;
        int   n;
        n = n0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        while (done !== 1'b1 && n < 40) begin
            check({e.tag, "_busy"}, 32'(busy), 32'd1);
            check({e.tag, "_res_hold"}, 32'(res), 32'(last_res));
            @(negedge clk);
            n++;
        end
        check({e.tag, "_done"}, 32'(done), 32'd1);
        check({e.tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({e.tag, "_latency"}, 32'(n), 32'(e.lat));
        check({e.tag, "_res"}, 32'(res), 32'(e.res));
        check({e.tag, "_rem"}, 32'(rem), 32'(e.rem));
        check({e.tag, "_div0"}, 32'(div0), 32'(e.div0));
        last_res = e.res;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fct   = 2'b00;
        a_v   = '0;
        b_v   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_div0", 32'(div0), 32'd0);

        // Release and start in the same cycle: first edge must accept
        rst_n = 1'b1;
        issue(2'b00, 8'd200, 8'd100, "add_200_100");
        wait_done(1);
        issue(2'b01, 8'd5, 8'd7, "sub_5_7");
        wait_done(1);

        // MUL with an ADD start attempted at edge T+3 while busy
        issue(2'b10, 8'd255, 8'd255, "mul_255_255");
        check("mul_busy_t1", 32'(busy), 32'd1);
        check("mul_done_t1", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        fct = 2'b00; a_v = 8'd1; b_v = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4);

        issue(2'b11, 8'd200, 8'd7, "div_200_7");
        wait_done(1);
        issue(2'b11, 8'd9, 8'd0, "div_9_0");
        wait_done(1);

        // Back-to-back: new MUL accepted in the DIV's DONE cycle
        issue(2'b11, 8'd200, 8'd7, "b2b_div");
        wait_done(1);
        issue(2'b10, 8'd3, 8'd4, "b2b_mul");
        wait_done(1);

        // Back-to-back single-cycle ops
        issue(2'b00, 8'd255, 8'd255, "add_max");
        wait_done(1);
        issue(2'b01, 8'd0, 8'd255, "sub_wrap");
        wait_done(1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0] rf;
            logic [7:0] ra, rb;
            rf = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            issue(rf, ra, rb, $sformatf("rand%0d", i));
            wait_done(1);
            @(negedge clk);
            check("rand_idle_done", 32'(done), 32'd0);
        end

        // Asynchronous reset in the middle of a MUL
        issue(2'b10, 8'd15, 8'd15, "mul_aborted");
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        last_res = '0;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res", 32'(res), 32'd0);
        check("arst_rem", 32'(rem), 32'd0);
        check("arst_div0", 32'(div0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        issue(2'b00, 8'd1, 8'd1, "add_after_rst");
        wait_done(1);
        repeat (12) begin
            @(negedge clk);
            check("final_no_done", 32'(done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Port: clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port: start_i  input  1  request; sampled only when the FSM is in IDLE or DONE.
REQ-005 Port: fct_i  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-006 Port: a_i, b_i  input  WIDTH each  unsigned operands.
REQ-007 Port: busy_o  output  1  high while the FSM is in CALC.
REQ-008 Port: done_o  output  1  one-cycle pulse, high while the FSM is in DONE.
REQ-009 Port: res_o  output  2*WIDTH  result.
REQ-010 Port: rem_o  output  2*WIDTH  remainder; zero for ADD, SUB and MUL.
REQ-011 Port: div0_o  output  1  high when the last completed operation was DIV with b = 0.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE, with these transitions:
- IDLE or DONE, start_i=1, ADD/SUB: go to DONE.
- IDLE or DONE, start_i=1, DIV with b_i=0: go to DONE.
- IDLE or DONE, start_i=1, MUL or DIV with b_i!=0: go to CALC.
- DONE, start_i=0: go to IDLE.
- CALC: go to DONE after exactly WIDTH iterations.
REQ-013 On an accepted start, the block SHALL latch a_i, b_i and fct_i, and SHALL ignore later changes to those inputs until DONE.
REQ-014 While in CALC, start_i SHALL be ignored; no queuing, no abort.
REQ-015 ADD SHALL be computed with both operands zero-extended to 2*WIDTH; res_o = a+b.
REQ-016 SUB SHALL give res_o = (a-b) mod 2^(2*WIDTH); a negative difference appears as a two's-complement value.
REQ-017 MUL SHALL use radix-2 shift-add, one partial product per CALC cycle; res_o = a*b exactly.
REQ-018 DIV SHALL use restoring division, one quotient bit per CALC cycle, MSB first; res_o = floor(a/b) and rem_o = a mod b, both zero-extended.
REQ-019 DIV with b = 0 SHALL give res_o=0 and rem_o=0 with div0_o=1; every other operation SHALL give div0_o=0.
REQ-020 With start accepted at edge T, done_o SHALL be high during cycle T+1 for ADD, SUB and DIV-by-0, and during cycle T+WIDTH+1 for MUL and DIV.
REQ-021 res_o, rem_o and div0_o SHALL update only on entry to DONE and SHALL hold their values until the next entry to DONE; intermediate iteration values SHALL never be visible on them.
REQ-022 A start accepted in DONE (back-to-back) SHALL begin the new operation with no idle cycle, and SHALL leave the just-completed results visible during that DONE cycle.
REQ-023 busy_o and done_o SHALL never be high in the same cycle.

Reset
REQ-024 When rst_ni=0, the FSM SHALL go to IDLE immediately, independent of clk_i, and all outputs SHALL be 0: busy_o, done_o, res_o, rem_o, div0_o.
REQ-025 Reset asserted mid-CALC SHALL abort the operation, discard partial results, and produce no done_o pulse.
REQ-026 The first start SHALL be accepted on the first rising edge after rst_ni is released.

Structure
REQ-027 Shared package alu_pkg SHALL hold:
- the fct_e enum (FCT_ADD, FCT_SUB, FCT_MUL, FCT_DIV with codes 00, 01, 10, 11);
- the state_e enum (IDLE, CALC, DONE).
REQ-028 The iteration datapath (shift-add step and restore-subtract step, width-parameterised, combinational) SHALL be the single sub-module alu_iter_step; the FSM, iteration counter ($clog2(WIDTH+1) bits) and registers SHALL live in alu_seq.

Verification (WIDTH=8, start at edge T)
REQ-029 ADD a=200 b=100 -> done_o at T+1, res_o=0x012C, rem_o=0, div0_o=0; SUB a=5 b=7 -> res_o=0xFFFE.
REQ-030 MUL a=255 b=255 -> busy_o high for cycles T+1..T+8, done_o at T+9, res_o=0xFE01; a start with ADD 1+1 at T+3 is ignored and res_o stays unchanged until T+9.
REQ-031 DIV a=200 b=7 -> done_o at T+9, res_o=28, rem_o=4; DIV a=9 b=0 -> done_o at T+1, res_o=0, rem_o=0, div0_o=1.
REQ-032 Back-to-back: DIV 200/7, then start MUL 3*4 in its DONE cycle -> first done_o shows 28/4; second done_o nine cycles later shows res_o=12, rem_o=0.
REQ-033 Reset mid-op: MUL 15*15, rst_ni=0 asynchronously between edges T+4 and T+5 -> all outputs 0 immediately, no done_o; after release, ADD 1+1 -> res_o=2 one cycle after start.
